tube_digi_translator: RTL and testbench

Hex-digit to seven-segment pattern encoder for the board's multiplexed tube displays. It converts one 4-bit nibble, plus decimal-point and blank requests, into an 8-bit segment pattern and registers it for one cycle. One instance sits behind each digit-select multiplexer of the tube display driver. The driver feeds it the currently scanned nibble and routes `Out` directly to the tube segment pins.

---
 rtl/tube_digi_translator.sv | 74 +++++++
 tb/tb_tube_digi_translator.sv | 114 +++++++++++
 2 files changed

// File: rtl/tube_digi_translator.sv
// tube_digi_translator
//   Hex-nibble to seven-segment encoder for the multiplexed tube displays.
//   The pattern is registered, so inputs reach Out one clock later.
//
// Parameters
//   ACTIVE_LOW : 1 = a lit segment drives 0, 0 = a lit segment drives 1
//
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; loads the unlit pattern
//   Num    : hex digit 0x0-0xF
//   Dp     : 1 lights the decimal point
//   Blank  : 1 turns every segment off, decimal point included
//   Out    : registered pattern {dp, a, b, c, d, e, f, g}
module tube_digi_translator #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Num,
  input  logic       Dp,
  input  logic       Blank,
  output logic [7:0] Out
);

  localparam logic [7:0] UNLIT = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] seg_al;
  logic [7:0] out_d;
  logic [7:0] out_q;

  // Glyphs are built in active-low form and inverted at the end when needed.
  always_comb begin
    seg_al = 8'hFF;
    case (Num)
      4'h0: seg_al = 8'h81;
      4'h1: seg_al = 8'hCF;
      4'h2: seg_al = 8'h92;
      4'h3: seg_al = 8'h86;
      4'h4: seg_al = 8'hCC;
      4'h5: seg_al = 8'hA4;
      4'h6: seg_al = 8'hA0;
      4'h7: seg_al = 8'h8F;
      4'h8: seg_al = 8'h80;
      4'h9: seg_al = 8'h84;
      4'hA: seg_al = 8'h88;
      4'hB: seg_al = 8'hE0;
      4'hC: seg_al = 8'hB1;
      4'hD: seg_al = 8'hC2;
      4'hE: seg_al = 8'hB0;
      4'hF: seg_al = 8'hB8;
      default: seg_al = 8'hFF;
    endcase
    if (Dp) begin
      seg_al[7] = 1'b0;
    end
    // Blank wins over both the digit and the decimal point.
    if (Blank) begin
      seg_al = 8'hFF;
    end
    out_d = ACTIVE_LOW ? seg_al : ~seg_al;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= UNLIT;
    end else begin
      out_q <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_tube_digi_translator.sv
module tb_tube_digi_translator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] num;
  logic       dp;
  logic       blank;
  logic [7:0] out_al;
  logic [7:0] out_ah;

  int total = 0;
  int bad   = 0;

  logic [7:0] glyph [16];

  always #5 clk = ~clk;

  tube_digi_translator #(.ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .Num   (num),
    .Dp    (dp),
    .Blank (blank),
    .Out   (out_al)
  );

  tube_digi_translator #(.ACTIVE_LOW(1'b0)) dut_n (
    .clk   (clk),
    .reset (reset),
    .Num   (num),
    .Dp    (dp),
    .Blank (blank),
    .Out   (out_ah)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    glyph[0]  = 8'h81; glyph[1]  = 8'hCF; glyph[2]  = 8'h92; glyph[3]  = 8'h86;
    glyph[4]  = 8'hCC; glyph[5]  = 8'hA4; glyph[6]  = 8'hA0; glyph[7]  = 8'h8F;
    glyph[8]  = 8'h80; glyph[9]  = 8'h84; glyph[10] = 8'h88; glyph[11] = 8'hE0;
    glyph[12] = 8'hB1; glyph[13] = 8'hC2; glyph[14] = 8'hB0; glyph[15] = 8'hB8;

    reset = 1'b1; num = 4'h8; dp = 1'b0; blank = 1'b0;
    step();
    chk("reset_edge1", out_al, 8'hFF);
    chk("reset_edge1_ah", out_ah, 8'h00);
    step();
    chk("reset_edge2", out_al, 8'hFF);

    reset = 1'b0;
    step();
    chk("release_8", out_al, 8'h80);
    chk("release_8_ah", out_ah, 8'h7F);

    for (int i = 0; i < 16; i++) begin
      num = i[3:0];
      step();
      chk($sformatf("sweep_%0h", i), out_al, glyph[i]);
      if (i == 1) chk("sweep_1_ah", out_ah, 8'h30);
      if (i == 0) chk("sweep_0_ah", out_ah, 8'h7E);
    end

    num = 4'h3; dp = 1'b1;
    step();
    chk("dp_3", out_al, 8'h06);
    num = 4'hF;
    step();
    chk("dp_F", out_al, 8'h38);
    dp = 1'b0;
    step();
    chk("dp_off_F", out_al, 8'hB8);

    num = 4'h0; dp = 1'b1; blank = 1'b1;
    step();
    chk("blank_dp", out_al, 8'hFF);
    chk("blank_dp_ah", out_ah, 8'h00);
    blank = 1'b0;
    step();
    chk("unblank_0_dp", out_al, 8'h01);
    chk("unblank_0_dp_ah", out_ah, 8'hFE);
    dp = 1'b0;

    num = 4'h4;
    step();
    chk("mid_4", out_al, 8'hCC);
    num = 4'h5; reset = 1'b1;
    step();
    chk("mid_reset_5", out_al, 8'hFF);
    chk("mid_reset_5_ah", out_ah, 8'h00);
    num = 4'h6; reset = 1'b0;
    step();
    chk("mid_resume_6", out_al, 8'hA0);
    num = 4'h7;
    step();
    chk("mid_resume_7", out_al, 8'h8F);
    chk("mid_resume_7_ah", out_ah, 8'h70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
